// File: rtl/bcd_dec10_stream_if.sv
// ----------------------------------------------------------------------------
// bcd_dec10_stream_if
// Handshake bundle for the streaming BCD-to-decimal decoder.
//   in_valid  : producer has a BCD digit on in_bcd
//   in_ready  : decoder can accept a digit
//   in_bcd    : 4-bit BCD digit, bit3 = MSB
//   out_valid : out_d/out_err carry a buffered result
//   out_ready : consumer accepts the current result
//   out_d     : one-hot decimal line (digit k drives bit 9-k)
//   out_err   : result came from an illegal code (10..15)
// master = stream source/sink around the decoder, slave = the decoder itself.
// ----------------------------------------------------------------------------
interface bcd_dec10_stream_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_bcd;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_d;
    logic       out_err;

    modport master (
        output in_valid, in_bcd, out_ready,
        input  in_ready, out_valid, out_d, out_err
    );

    modport slave (
        input  in_valid, in_bcd, out_ready,
        output in_ready, out_valid, out_d, out_err
    );
endinterface

// File: rtl/bcd_dec10_stream.sv
// ----------------------------------------------------------------------------
// bcd_dec10_stream
// Streaming BCD-to-decimal decoder. Each accepted BCD digit is decoded to a
// 10-bit one-hot decimal line (digit k -> bit 9-k) plus an error flag for the
// illegal codes 10..15, and the 11-bit result is buffered in a small FIFO so
// the output side may stall. A saturating counter tracks accepted illegal
// codes.
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous, active-low reset
//   bus     : handshake bundle (slave side), see bcd_dec10_stream_if
//   clr_err : synchronous clear of err_cnt (wins over the old count)
//   err_cnt : saturating count of accepted illegal codes
// Parameters:
//   FIFO_DEPTH : buffer entries, power of two, >= 2
//   ERR_CNT_W  : width of err_cnt
// ----------------------------------------------------------------------------
module bcd_dec10_stream #(
    parameter int FIFO_DEPTH = 2,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_dec10_stream_if.slave    bus,
    input  logic                 clr_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    // Decode happens before the write, so each entry is {err, d[9:0]}.
    function automatic logic [10:0] f_decode(input logic [3:0] bcd);
        logic [10:0] v;
        v = '0;
        case (bcd)
            4'd0:    v = 11'b0_1000000000;
            4'd1:    v = 11'b0_0100000000;
            4'd2:    v = 11'b0_0010000000;
            4'd3:    v = 11'b0_0001000000;
            4'd4:    v = 11'b0_0000100000;
            4'd5:    v = 11'b0_0000010000;
            4'd6:    v = 11'b0_0000001000;
            4'd7:    v = 11'b0_0000000100;
            4'd8:    v = 11'b0_0000000010;
            4'd9:    v = 11'b0_0000000001;
            default: v = 11'b1_0000000000;
        endcase
        return v;
    endfunction

    logic [10:0]          r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_in_ready;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_illegal_push;
    logic                 w_out_valid;
    logic [CNT_W-1:0]     w_count_nxt;
    logic [10:0]          w_head;

    assign w_out_valid    = (r_count != '0);
    assign w_push         = bus.in_valid && r_in_ready;
    assign w_pop          = w_out_valid && bus.out_ready;
    assign w_illegal_push = w_push && (bus.in_bcd > 4'd9);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // in_ready is registered from the next occupancy, so out_ready never
    // reaches it combinationally; it stays low in reset and rises on the
    // first edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt != FULL_CNT);
        end
    end

    // Entry storage carries no reset; unwritten entries are never exposed
    // because the output is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= f_decode(bus.in_bcd);
        end
    end

    // Clear takes priority over the old value but still counts an illegal
    // code pushed in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_cnt <= '0;
        end else if (clr_err) begin
            r_err_cnt <= w_illegal_push ? ERR_CNT_W'(1) : '0;
        end else if (w_illegal_push && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
    end

    assign w_head        = r_mem[r_rd_ptr];
    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_d     = w_out_valid ? w_head[9:0] : 10'd0;
    assign bus.out_err   = w_out_valid ? w_head[10]  : 1'b0;
    assign err_cnt       = r_err_cnt;

endmodule
